lineattr_ctrl: RTL and testbench
================================

# lineattr_ctrl

Write-port controller for the 256 × 2-bit line attribute buffer in the AQMS video path. It shares the buffer's single write port between the sprite renderer and a built-in clear sequencer. The clear sequencer wipes all 256 entries once per scanline after display readout. An optional occupancy tracker gives first-writer-wins priority and flags sprite collisions. The display read port (`idx2`/`rddata2`) connects directly to the buffer and does not pass through this block.

## Interface
Parameters: none; widths are fixed by the package constants.

Ports:
- `clk`  in  1  video clock; also clocks the buffer.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear_start`  in  1  one-cycle pulse from video timing at hblank start: begin the line clear.
- `rend_valid`  in  1  renderer write request.
- `rend_idx`  in  8  pixel x index for the renderer write.
- `rend_data`  in  2  attribute value for the renderer write.
- `rend_ready`  out  1  write accepted on a clock edge where `rend_valid & rend_ready`.
- `clear_busy`  out  1  clear sequence in progress.
- `clear_done`  out  1  one-cycle pulse with the final clear write.
- `collision`  out  1  sticky collision flag.
- `collision_clr`  in  1  one-cycle pulse that clears `collision`.
- `buf_idx`  out  8  drives buffer `idx1`.
- `buf_wrdata`  out  2  drives buffer `wrdata1`.
- `buf_wren`  out  1  drives buffer `wren1`.

## Operation
- States: `S_CLEAR` and `S_OPEN`. `clear_cnt` is an 8-bit counter.
- Reset enters `S_CLEAR` with `clear_cnt`=0, because buffer contents are undefined at power-up.
- `S_OPEN`:
  - `rend_ready` = `!clear_start`.
  - An accepted write is forwarded to the buffer outputs.
  - `clear_start`=1 moves to `S_CLEAR` with `clear_cnt`=0. The renderer is refused in that cycle.
- `S_CLEAR`:
  - `rend_ready`=0.
  - Each cycle issues a write of 2'b00 to `clear_cnt`, then increments `clear_cnt`.
  - After the write to index 255, move to `S_OPEN`.
  - `clear_start` during `S_CLEAR` restarts the sequence with `clear_cnt`=0.
- `clear_busy` = (state == `S_CLEAR`).
- The clear sequencer always has priority. The renderer never stalls `S_CLEAR`.
- Reset asserted mid-sequence or mid-write: all registers return to reset values immediately. No partial write is issued after reset deasserts.

## Timing
- Reset values:
  - `buf_wren`=0, `buf_idx`=0, `buf_wrdata`=0.
  - `rend_ready`=0, `clear_busy`=1, `clear_done`=0, `collision`=0.
- `buf_idx`, `buf_wrdata` and `buf_wren` are registered. `rend_ready` and `clear_busy` are decoded from state.
- Renderer write:
  - Accepted at edge E.
  - `buf_wren`=1 with the captured index and data after E, for exactly one cycle.
  - Back-to-back writes are allowed at one per cycle.
- Clear sequence, with `clear_start` sampled at edge E0:
  - After E0: `clear_busy`=1.
  - After edge E(k+1): `buf_idx`=k with `buf_wren`=1, for k = 0..255.
  - After E256: `clear_done`=1 for one cycle, `clear_busy`=0, `rend_ready`=1.
  - Total: exactly 256 write cycles.
- If `clear_start` and an accepted renderer write fall in the same cycle, the write is refused. This follows from `rend_ready`=0 in that cycle.

## Configuration
- Macro: `LINEATTR_COLLISION_EN`.
- Defined:
  - A 256-bit occupancy map `occ` is kept alongside the buffer.
  - Clear sequence: all `occ` bits are cleared on entry to `S_CLEAR`.
  - Accepted write with `rend_data`=2'b00: treated as transparent and dropped. No buffer write occurs.
  - Accepted write, data nonzero, `occ[idx]`=0: the write proceeds and `occ[idx]` is set.
  - Accepted write, data nonzero, `occ[idx]`=1: the write is dropped and `collision` is set on the next edge.
  - Dropped writes still complete the handshake.
  - `collision` and `collision_clr` in the same cycle: the set wins.
- Not defined:
  - Every accepted write, including 2'b00, is forwarded.
  - `collision` is tied to 0. `collision_clr` is ignored.
  - No `occ` storage is built.

## Structure
- Package `lineattr_pkg`:
  - `LINE_PIXELS`=256, `IDX_W`=8, `ATTR_W`=2.
  - State enum `lineattr_state_t` {`S_CLEAR`, `S_OPEN`}.
  - `ATTR_TRANSPARENT`=2'b00.
- Sub-module `lineattr_occupancy`:
  - Contains the 256-bit map, test-and-set port and bulk clear.
  - Instantiated only under `LINEATTR_COLLISION_EN`.
- This block has no other children. The buffer is instantiated alongside it by the parent.

## Test plan
- Reset release: `clear_busy`=1 for 256 cycles. `buf_idx` steps 0..255 with `buf_wren`=1 and `buf_wrdata`=0. `clear_done` pulses once, then `rend_ready`=1.
- Renderer burst in `S_OPEN`: writes (idx 10, 2'b01), (idx 11, 2'b10), (idx 12, 2'b11) on consecutive cycles. Each appears on the buffer port exactly one cycle later. Buffer readback of idx 10/11/12 returns 1/2/3.
- `clear_start` coincident with `rend_valid`: the renderer is refused. The next cycle is `S_CLEAR` and the first clear write targets idx 0. The renderer write goes through only after `clear_done`.
- `clear_start` re-pulsed at `clear_cnt`=100: the sequence restarts at idx 0. `clear_done` arrives 256 cycles after the re-pulse.
- With `LINEATTR_COLLISION_EN` defined:
  - Write (idx 5, 2'b10), then (idx 5, 2'b01): the second write is dropped, `collision`=1 and buffer idx 5 reads 2'b10.
  - (idx 6, 2'b00): no `buf_wren`.
  - `collision_clr` pulsed together with a new collision: `collision` stays 1.
- Reset asserted at `clear_cnt`=40 while `buf_wren`=1: `buf_wren` drops at once. After release the sequence restarts at idx 0.

Source files
------------

// File: rtl/lineattr_pkg.sv
// Shared constants and types for the line attribute buffer write-port controller.
// Build option: LINEATTR_COLLISION_EN enables the occupancy tracker.
package lineattr_pkg;

  localparam int unsigned LINE_PIXELS = 256;
  localparam int unsigned IDX_W       = 8;
  localparam int unsigned ATTR_W      = 2;

  localparam logic [ATTR_W-1:0] ATTR_TRANSPARENT = 2'b00;
  localparam logic [IDX_W-1:0]  IDX_LAST         = IDX_W'(LINE_PIXELS - 1);

  typedef enum logic {
    S_CLEAR,
    S_OPEN
  } lineattr_state_t;

endpackage

// File: rtl/lineattr_occupancy.sv
// Per-pixel occupancy map: combinational test, registered set, bulk clear.
// Only instantiated when LINEATTR_COLLISION_EN is defined.
module lineattr_occupancy
  import lineattr_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bulk_clr,
  input  logic             set_en,
  input  logic [IDX_W-1:0] idx,
  output logic             occupied
);

  logic [LINE_PIXELS-1:0] occ;

  assign occupied = occ[idx];

  // Map storage: bulk clear has priority over a single-bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ <= '0;
    end else if (bulk_clr) begin
      occ <= '0;
    end else if (set_en) begin
      occ[idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/lineattr_ctrl.sv
// Write-port arbiter for the 256 x 2-bit line attribute buffer.
// A clear sequencer wipes the buffer once per line and always beats the renderer.
// Build option: LINEATTR_COLLISION_EN adds first-writer-wins occupancy tracking
// and a sticky sprite collision flag.
module lineattr_ctrl
  import lineattr_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_start,
  input  logic              rend_valid,
  input  logic [IDX_W-1:0]  rend_idx,
  input  logic [ATTR_W-1:0] rend_data,
  output logic              rend_ready,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              collision,
  input  logic              collision_clr,
  output logic [IDX_W-1:0]  buf_idx,
  output logic [ATTR_W-1:0] buf_wrdata,
  output logic              buf_wren
);

  lineattr_state_t   state, state_nxt;
  logic [IDX_W-1:0]  clear_cnt, clear_cnt_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [ATTR_W-1:0] wrdata_nxt;
  logic              wren_nxt;
  logic              done_nxt;
  logic              rend_accept;

`ifdef LINEATTR_COLLISION_EN
  logic occ_clr;
  logic occ_set;
  logic occ_hit;
  logic coll_hit;
`endif

  assign clear_busy  = (state == S_CLEAR);
  assign rend_ready  = (state == S_OPEN) && !clear_start;
  assign rend_accept = rend_valid && rend_ready;

  // Next-state, clear sequencing and write-port selection.
  always_comb begin
    state_nxt     = state;
    clear_cnt_nxt = clear_cnt;
    idx_nxt       = buf_idx;
    wrdata_nxt    = buf_wrdata;
    wren_nxt      = 1'b0;
    done_nxt      = 1'b0;
`ifdef LINEATTR_COLLISION_EN
    occ_clr       = 1'b0;
    occ_set       = 1'b0;
    coll_hit      = 1'b0;
`endif
    if (clear_start) begin
      // Entering or restarting the clear: no buffer write on this edge.
      state_nxt     = S_CLEAR;
      clear_cnt_nxt = '0;
`ifdef LINEATTR_COLLISION_EN
      occ_clr       = 1'b1;
`endif
    end else begin
      case (state)
        S_CLEAR: begin
          wren_nxt      = 1'b1;
          idx_nxt       = clear_cnt;
          wrdata_nxt    = ATTR_TRANSPARENT;
          clear_cnt_nxt = clear_cnt + 1'b1;
          if (clear_cnt == IDX_LAST) begin
            done_nxt  = 1'b1;
            state_nxt = S_OPEN;
          end
        end
        S_OPEN: begin
          if (rend_accept) begin
`ifdef LINEATTR_COLLISION_EN
            // Transparent and second-writer requests complete the handshake but are dropped.
            if (rend_data != ATTR_TRANSPARENT) begin
              if (occ_hit) begin
                coll_hit = 1'b1;
              end else begin
                wren_nxt   = 1'b1;
                idx_nxt    = rend_idx;
                wrdata_nxt = rend_data;
                occ_set    = 1'b1;
              end
            end
`else
            wren_nxt   = 1'b1;
            idx_nxt    = rend_idx;
            wrdata_nxt = rend_data;
`endif
          end
        end
      endcase
    end
  end

  // State, counter and registered buffer port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_CLEAR;
      clear_cnt  <= '0;
      buf_idx    <= '0;
      buf_wrdata <= '0;
      buf_wren   <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clear_cnt  <= clear_cnt_nxt;
      buf_idx    <= idx_nxt;
      buf_wrdata <= wrdata_nxt;
      buf_wren   <= wren_nxt;
      clear_done <= done_nxt;
    end
  end

`ifdef LINEATTR_COLLISION_EN
  lineattr_occupancy u_occ (
    .clk      (clk),
    .reset_n  (reset_n),
    .bulk_clr (occ_clr),
    .set_en   (occ_set),
    .idx      (rend_idx),
    .occupied (occ_hit)
  );

  // Sticky collision flag: a new collision outranks a clear request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collision <= 1'b0;
    end else if (coll_hit) begin
      collision <= 1'b1;
    end else if (collision_clr) begin
      collision <= 1'b0;
    end
  end
`else
  logic unused_collision_clr;
  assign unused_collision_clr = collision_clr;
  assign collision            = 1'b0;
`endif

endmodule

// File: tb/tb_lineattr_ctrl.sv
// Self-checking bench for lineattr_ctrl with a behavioural line-clear/renderer model.
// Collision scenarios run only when LINEATTR_COLLISION_EN is defined.
module tb_lineattr_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear_start, rend_valid, collision_clr;
  logic [7:0] rend_idx;
  logic [1:0] rend_data;
  logic       rend_ready, clear_busy, clear_done, collision, buf_wren;
  logic [7:0] buf_idx;
  logic [1:0] buf_wrdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lineattr_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear_start   (clear_start),
    .rend_valid    (rend_valid),
    .rend_idx      (rend_idx),
    .rend_data     (rend_data),
    .rend_ready    (rend_ready),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done),
    .collision     (collision),
    .collision_clr (collision_clr),
    .buf_idx       (buf_idx),
    .buf_wrdata    (buf_wrdata),
    .buf_wren      (buf_wren)
  );

  // Attribute buffer as the parent would attach it.
  logic [1:0] dut_buf [256];
  always @(posedge clk) if (buf_wren === 1'b1) dut_buf[buf_idx] <= buf_wrdata;

  // Reference model: edges elapsed since the clear began (256+ means line open).
  int         m_since;
  bit         m_occ [256];
  bit         m_coll;
  bit         exp_wren, exp_done, exp_ready;
  logic [7:0] exp_idx;
  logic [1:0] exp_data;
  logic       pre_ready;

  task automatic model_reset();
    m_since  = 0;
    m_coll   = 0;
    exp_wren = 0;
    exp_done = 0;
    foreach (m_occ[i]) m_occ[i] = 0;
  endtask

  task automatic model_edge(input bit cs, input bit rv, input logic [7:0] ri,
                            input logic [1:0] rd, input bit cc);
`ifdef LINEATTR_COLLISION_EN
    bit hit = 0;
`endif
    exp_wren = 0;
    exp_done = 0;
    if (cs) begin
      m_since = 0;
      foreach (m_occ[i]) m_occ[i] = 0;
    end else if (m_since < 256) begin
      exp_wren = 1;
      exp_idx  = m_since[7:0];
      exp_data = 2'b00;
      exp_done = (m_since == 255);
      m_since++;
    end else if (rv) begin
`ifdef LINEATTR_COLLISION_EN
      if (rd != 2'b00) begin
        if (m_occ[ri]) hit = 1;
        else begin
          m_occ[ri] = 1;
          exp_wren  = 1;
          exp_idx   = ri;
          exp_data  = rd;
        end
      end
`else
      exp_wren = 1;
      exp_idx  = ri;
      exp_data = rd;
`endif
    end
`ifdef LINEATTR_COLLISION_EN
    if (hit) m_coll = 1;
    else if (cc) m_coll = 0;
`else
    if (cc) m_coll = 0;
`endif
  endtask

  // Drive one cycle of inputs, sample rend_ready before the edge, advance model past the edge.
  task automatic tick(input bit cs, input bit rv, input logic [7:0] ri,
                      input logic [1:0] rd, input bit cc);
    clear_start = cs; rend_valid = rv; rend_idx = ri; rend_data = rd; collision_clr = cc;
    #1;
    pre_ready = rend_ready;
    exp_ready = (m_since >= 256) && !cs;
    @(posedge clk);
    model_edge(cs, rv, ri, rd, cc);
    #1;
    clear_start = 0; rend_valid = 0; collision_clr = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; clear_start = 0; rend_valid = 0; rend_idx = 0; rend_data = 0; collision_clr = 0;
    #23;
    tests++; if (buf_wren !== 1'b0)   begin fails++; $display("FAIL reset_wren got %b want 0", buf_wren); end
    tests++; if (buf_idx !== 8'd0)    begin fails++; $display("FAIL reset_idx got %0d want 0", buf_idx); end
    tests++; if (buf_wrdata !== 2'd0) begin fails++; $display("FAIL reset_data got %0d want 0", buf_wrdata); end
    tests++; if (rend_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", rend_ready); end
    tests++; if (clear_busy !== 1'b1) begin fails++; $display("FAIL reset_busy got %b want 1", clear_busy); end
    tests++; if (clear_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", clear_done); end
    tests++; if (collision !== 1'b0)  begin fails++; $display("FAIL reset_coll got %b want 0", collision); end
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_clear_sweep(input string name, input bit rend_try);
    int dones = 0;
    for (int k = 0; k < 256; k++) begin
      tick(0, rend_try, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3)), 0);
      if (clear_done === 1'b1) dones++;
      tests++; if (pre_ready !== exp_ready) begin fails++; $display("FAIL %s_ready k=%0d got %b want %b", name, k, pre_ready, exp_ready); end
      tests++; if (buf_wren !== 1'b1 || buf_idx !== 8'(k) || buf_wrdata !== 2'b00) begin
        fails++; $display("FAIL %s_write k=%0d got wren=%b idx=%0d data=%0d want 1/%0d/0", name, k, buf_wren, buf_idx, buf_wrdata, k); end
      tests++; if (clear_busy !== (k < 255)) begin fails++; $display("FAIL %s_busy k=%0d got %b want %b", name, k, clear_busy, k < 255); end
      tests++; if (clear_done !== (k == 255)) begin fails++; $display("FAIL %s_done k=%0d got %b want %b", name, k, clear_done, k == 255); end
    end
    tests++; if (dones != 1) begin fails++; $display("FAIL %s_done_count got %0d want 1", name, dones); end
    #1;
    tests++; if (rend_ready !== 1'b1) begin fails++; $display("FAIL %s_open_ready got %b want 1", name, rend_ready); end
  endtask

  task automatic test_burst();
    logic [7:0] ids [3] = '{8'd10, 8'd11, 8'd12};
    logic [1:0] ds  [3] = '{2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, ids[i], ds[i], 0);
      tests++; if (pre_ready !== 1'b1) begin fails++; $display("FAIL burst_ready i=%0d got %b want 1", i, pre_ready); end
      tests++; if (buf_wren !== 1'b1 || buf_idx !== ids[i] || buf_wrdata !== ds[i]) begin
        fails++; $display("FAIL burst_write i=%0d got %b/%0d/%0d want 1/%0d/%0d", i, buf_wren, buf_idx, buf_wrdata, ids[i], ds[i]); end
    end
    tick(0, 0, 0, 0, 0);
    tests++; if (buf_wren !== 1'b0) begin fails++; $display("FAIL burst_idle_wren got %b want 0", buf_wren); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (dut_buf[ids[i]] !== ds[i]) begin fails++; $display("FAIL burst_readback idx=%0d got %0d want %0d", ids[i], dut_buf[ids[i]], ds[i]); end
    end
    tests++; if (dut_buf[13] !== 2'd0) begin fails++; $display("FAIL burst_cleared idx=13 got %0d want 0", dut_buf[13]); end
  endtask

  task automatic test_clear_coincident();
    tick(1, 1, 8'd20, 2'd3, 0);
    tests++; if (pre_ready !== 1'b0) begin fails++; $display("FAIL coinc_ready got %b want 0", pre_ready); end
    tests++; if (buf_wren !== 1'b0 || clear_busy !== 1'b1) begin
      fails++; $display("FAIL coinc_refused got wren=%b busy=%b want 0/1", buf_wren, clear_busy); end
    test_clear_sweep("coinc", 1);
    tick(0, 1, 8'd20, 2'd3, 0);
    tests++; if (buf_wren !== 1'b1 || buf_idx !== 8'd20 || buf_wrdata !== 2'd3) begin
      fails++; $display("FAIL coinc_after got %b/%0d/%0d want 1/20/3", buf_wren, buf_idx, buf_wrdata); end
  endtask

  task automatic test_restart();
    int done_at = -1;
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 100; k++) tick(0, 0, 0, 0, 0);
    tests++; if (buf_idx !== 8'd99 || clear_busy !== 1'b1) begin
      fails++; $display("FAIL restart_pre got idx=%0d busy=%b want 99/1", buf_idx, clear_busy); end
    tick(1, 0, 0, 0, 0);
    tests++; if (buf_wren !== 1'b0) begin fails++; $display("FAIL restart_edge_wren got %b want 0", buf_wren); end
    for (int k = 0; k < 260; k++) begin
      tick(0, 0, 0, 0, 0);
      if (clear_done === 1'b1 && done_at < 0) done_at = k;
      if (k == 0) begin
        tests++; if (buf_wren !== 1'b1 || buf_idx !== 8'd0) begin
          fails++; $display("FAIL restart_first got wren=%b idx=%0d want 1/0", buf_wren, buf_idx); end
      end
    end
    tests++; if (done_at != 255) begin fails++; $display("FAIL restart_done_at got %0d want 255", done_at); end
  endtask

`ifdef LINEATTR_COLLISION_EN
  task automatic test_collision();
    tick(0, 1, 8'd5, 2'b10, 0);
    tests++; if (buf_wren !== 1'b1 || buf_idx !== 8'd5) begin fails++; $display("FAIL coll_first got %b/%0d want 1/5", buf_wren, buf_idx); end
    tick(0, 1, 8'd5, 2'b01, 0);
    tests++; if (pre_ready !== 1'b1) begin fails++; $display("FAIL coll_handshake got %b want 1", pre_ready); end
    tests++; if (buf_wren !== 1'b0 || collision !== 1'b1) begin
      fails++; $display("FAIL coll_second got wren=%b coll=%b want 0/1", buf_wren, collision); end
    tick(0, 1, 8'd6, 2'b00, 0);
    tests++; if (buf_wren !== 1'b0) begin fails++; $display("FAIL coll_transparent got %b want 0", buf_wren); end
    tests++; if (dut_buf[5] !== 2'b10) begin fails++; $display("FAIL coll_readback got %0d want 2", dut_buf[5]); end
    tick(0, 1, 8'd5, 2'b11, 1);
    tests++; if (collision !== 1'b1) begin fails++; $display("FAIL coll_set_wins got %b want 1", collision); end
    tick(0, 0, 0, 0, 1);
    tests++; if (collision !== 1'b0) begin fails++; $display("FAIL coll_clr got %b want 0", collision); end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 1200; n++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 31)),
           2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      tests++; if (pre_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready n=%0d got %b want %b", n, pre_ready, exp_ready); end
      tests++; if (buf_wren !== exp_wren) begin fails++; $display("FAIL rnd_wren n=%0d got %b want %b", n, buf_wren, exp_wren); end
      if (exp_wren) begin
        tests++; if (buf_idx !== exp_idx || buf_wrdata !== exp_data) begin
          fails++; $display("FAIL rnd_write n=%0d got %0d/%0d want %0d/%0d", n, buf_idx, buf_wrdata, exp_idx, exp_data); end
      end
      tests++; if (clear_done !== exp_done) begin fails++; $display("FAIL rnd_done n=%0d got %b want %b", n, clear_done, exp_done); end
      tests++; if (clear_busy !== (m_since < 256)) begin fails++; $display("FAIL rnd_busy n=%0d got %b want %b", n, clear_busy, m_since < 256); end
      tests++; if (collision !== m_coll) begin fails++; $display("FAIL rnd_coll n=%0d got %b want %b", n, collision, m_coll); end
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) tick(0, 0, 0, 0, 0);
    tests++; if (buf_wren !== 1'b1 || buf_idx !== 8'd39) begin
      fails++; $display("FAIL rstmid_pre got wren=%b idx=%0d want 1/39", buf_wren, buf_idx); end
    #2 reset_n = 0;
    #1;
    tests++; if (buf_wren !== 1'b0 || buf_idx !== 8'd0) begin
      fails++; $display("FAIL rstmid_async got wren=%b idx=%0d want 0/0", buf_wren, buf_idx); end
    tests++; if (clear_busy !== 1'b1 || clear_done !== 1'b0 || rend_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_state got busy=%b done=%b ready=%b want 1/0/0", clear_busy, clear_done, rend_ready); end
    model_reset();
    @(negedge clk);
    reset_n = 1;
    test_clear_sweep("rstmid", 0);
  endtask

  initial begin
    test_reset();
    test_clear_sweep("boot", 1);
    test_burst();
    test_clear_coincident();
    test_restart();
`ifdef LINEATTR_COLLISION_EN
    test_collision();
`endif
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
